debug_playback: RTL and testbench

DEBUG_PLAYBACK -- requirements
Module: debug_playback

---
 rtl/debug_pkg.sv | 12 +
 rtl/debug_playback_ram.sv | 32 +++
 rtl/debug_playback.sv | 177 +++++++++++++++++
 tb/tb_debug_playback.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// debug_pkg: shared types and default sizes for the debug playback buffer.
package debug_pkg;

  localparam int unsigned DEF_DWIDTH = 24;
  localparam int unsigned DEF_AWIDTH = 12;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

endpackage

// File: rtl/debug_playback_ram.sv
// debug_playback_ram: simple dual-port sample store, one write port, one
// registered read port, contents not reset.
module debug_playback_ram
  import debug_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // registered read port, one cycle latency
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/debug_playback.sv
// debug_playback: load a buffer of samples while idle, then replay them one
// per sample_tick with a fixed two-cycle tick-to-valid latency.
// Optional feature: define DEBUG_PLAYBACK_LOOP_EN to let the loop input wrap
// playback back to address 0 instead of finishing.
module debug_playback
  import debug_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_valid,
  input  logic [DWIDTH-1:0] load_data,
  input  logic              load_rewind,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  input  logic              sample_tick,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_out_valid,
  output logic              busy,
  output logic              full,
  output logic              done
);

  localparam int unsigned CW = AWIDTH + 1;

  state_e            state_q;
  state_e            state_d;
  logic              play_q;
  logic              rewind_q;
  logic              play_edge_c;
  logic              rewind_edge_c;
  logic [AWIDTH-1:0] wr_addr_q;
  logic [AWIDTH-1:0] rd_addr_q;
  logic [CW-1:0]     count_q;
  logic              wr_en_c;
  logic              rd_en_c;
  logic              rd_wrap_c;
  logic              last_rd_c;
  logic              empty_play_c;
  logic              start_c;
  logic              rd_pend_q;
  logic              last_pend_q;
  logic [DWIDTH-1:0] ram_rd_data;

  assign play_edge_c   = play && !play_q;
  assign rewind_edge_c = load_rewind && !rewind_q;

`ifndef DEBUG_PLAYBACK_LOOP_EN
  logic unused_loop;
  assign unused_loop = loop;
`endif

  // next-state and per-cycle control decode
  always_comb begin
    state_d      = state_q;
    wr_en_c      = 1'b0;
    rd_en_c      = 1'b0;
    rd_wrap_c    = 1'b0;
    last_rd_c    = 1'b0;
    empty_play_c = 1'b0;
    start_c      = 1'b0;
    case (state_q)
      IDLE: begin
        // a rewind edge in the same cycle suppresses the write
        wr_en_c = load_valid && !count_q[AWIDTH] && !rewind_edge_c;
        if (play_edge_c) begin
          if (count_q != '0) begin
            state_d = PLAY;
            start_c = 1'b1;
          end else begin
            empty_play_c = 1'b1;
          end
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else if (sample_tick) begin
          rd_en_c = 1'b1;
          if ({1'b0, rd_addr_q} == count_q - CW'(1)) begin
`ifdef DEBUG_PLAYBACK_LOOP_EN
            if (loop) begin
              rd_wrap_c = 1'b1;
            end else begin
              last_rd_c = 1'b1;
              state_d   = IDLE;
            end
`else
            last_rd_c = 1'b1;
            state_d   = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // registered copies for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      play_q   <= 1'b0;
      rewind_q <= 1'b0;
    end else begin
      play_q   <= play;
      rewind_q <= load_rewind;
    end
  end

  // write address and loaded count; rewind only honoured while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_q <= '0;
      count_q   <= '0;
    end else if (state_q == IDLE && rewind_edge_c) begin
      wr_addr_q <= '0;
      count_q   <= '0;
    end else if (wr_en_c) begin
      wr_addr_q <= wr_addr_q + AWIDTH'(1);
      count_q   <= count_q + CW'(1);
    end
  end

  // read address: cleared on start, advanced or wrapped per issued read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
    end else if (start_c || rd_wrap_c) begin
      rd_addr_q <= '0;
    end else if (rd_en_c) begin
      rd_addr_q <= rd_addr_q + AWIDTH'(1);
    end
  end

  // output pipeline: read issue -> RAM data -> data_out, done rides along
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q      <= 1'b0;
      last_pend_q    <= 1'b0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
      done           <= 1'b0;
    end else begin
      rd_pend_q      <= rd_en_c;
      last_pend_q    <= last_rd_c;
      data_out_valid <= rd_pend_q;
      if (rd_pend_q) data_out <= ram_rd_data;
      done           <= last_pend_q || empty_play_c;
    end
  end

  assign busy = (state_q == PLAY);
  assign full = count_q[AWIDTH];

  debug_playback_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr_q),
    .wr_data (load_data),
    .rd_en   (rd_en_c),
    .rd_addr (rd_addr_q),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_debug_playback.sv
// Scoreboard bench for debug_playback: stimulus pushes expected samples,
// a negedge monitor pops and compares on every data_out_valid.
module tb_debug_playback;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_rewind = 1'b0;
  logic          play = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic          sample_tick = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          busy;
  logic          full;
  logic          done;

  typedef struct {
    logic [DW-1:0] data;
    logic          done;
    int unsigned   due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_alone = 0;
  int          valid_cnt = 0;

  debug_playback #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_rewind    (load_rewind),
    .play           (play),
    .stop           (stop),
    .loop           (loop),
    .sample_tick    (sample_tick),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .busy           (busy),
    .full           (full),
    .done           (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every valid must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (data_out_valid) begin
        valid_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid data=%h done=%b cyc=%0d", data_out, done, cyc);
        end else begin
          e = sb_q.pop_front();
          if (data_out !== e.data || done !== e.done || cyc != e.due) begin
            errors++;
            $display("FAIL playback got data=%h done=%b cyc=%0d want data=%h done=%b cyc=%0d",
                     data_out, done, cyc, e.data, e.done, e.due);
          end
        end
      end else if (done) begin
        done_alone++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [DW-1:0] d);
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_data  = d;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic rewind();
    @(posedge clk); #1;
    load_rewind = 1'b1;
    @(posedge clk); #1;
    load_rewind = 1'b0;
  endtask

  task automatic play_edge();
    @(posedge clk); #1;
    play = 1'b1;
    @(posedge clk); #1;
    play = 1'b0;
  endtask

  task automatic tick(input logic [DW-1:0] d, input logic d_done);
    @(posedge clk); #1;
    sample_tick = 1'b1;
    sb_q.push_back('{data: d, done: d_done, due: cyc + 2});
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic tick_none();
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    idle(2);
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    idle(3);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;

    // play with nothing loaded: done next cycle, never busy
    @(posedge clk); #1;
    play = 1'b1;
    @(posedge clk); #1;
    check("empty_play_done", 32'(done), 32'd1);
    check("empty_play_busy", 32'(busy), 32'd0);
    play = 1'b0;
    @(posedge clk); #1;
    check("empty_play_done_once", 32'(done), 32'd0);
    idle(3);
    check("empty_play_done_cnt", 32'(done_alone), 32'd1);

    // four samples, tick every 10 cycles
    for (int i = 1; i <= 4; i++) load(DW'(i));
    check("four_full", 32'(full), 32'd0);
    play_edge();
    check("four_busy", 32'(busy), 32'd1);
    load(24'hEEEEEE);
    tick(24'h1, 1'b0); idle(8);
    tick(24'h2, 1'b0); idle(8);
    tick(24'h3, 1'b0); idle(8);
    tick(24'h4, 1'b1);
    drain();
    check("four_busy_after", 32'(busy), 32'd0);

    // replay: the load during busy must not have been stored
    play_edge();
    for (int i = 1; i <= 4; i++) tick(DW'(i), i == 4);
    drain();

    // ticks while idle produce nothing
    tick_none();
    tick_none();
    idle(4);
    check("idle_tick_valids", 32'(valid_cnt), 32'd8);

    // rewind and load_valid together: rewind wins
    @(posedge clk); #1;
    load_rewind = 1'b1;
    load_valid  = 1'b1;
    load_data   = 24'h000077;
    @(posedge clk); #1;
    load_rewind = 1'b0;
    load_valid  = 1'b0;
    load(24'h000055);
    play_edge();
    tick(24'h000055, 1'b1);
    drain();

    // stop after the second of three ticks
    rewind();
    load(24'h30); load(24'h31); load(24'h32);
    play_edge();
    tick(24'h30, 1'b0);
    tick(24'h31, 1'b0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    drain();
    tick_none();
    idle(4);
    check("stop_no_done", 32'(done_alone), 32'd1);

    // asynchronous reset mid-play
    play_edge();
    tick(24'h30, 1'b0);
    drain();
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(data_out_valid), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    play_edge();
    idle(3);
    check("arst_count_cleared", 32'(done_alone), 32'd2);
    check("arst_not_busy", 32'(busy), 32'd0);
    load(24'h000099);
    play_edge();
    tick(24'h000099, 1'b1);
    drain();

`ifdef DEBUG_PLAYBACK_LOOP_EN
    // looping over two samples
    rewind();
    load(24'h00000A); load(24'h00000B);
    loop = 1'b1;
    play_edge();
    tick(24'hA, 1'b0); tick(24'hB, 1'b0);
    tick(24'hA, 1'b0); tick(24'hB, 1'b0);
    tick(24'hA, 1'b0);
    loop = 1'b0;
    tick(24'hB, 1'b1);
    drain();
    check("loop_busy_after", 32'(busy), 32'd0);
`endif

    // fill the whole buffer, then one rejected write
    rewind();
    for (int i = 0; i < 4096; i++) begin
      load(DW'(i + 24'h100000));
      if (i == 4094) check("fill_not_full", 32'(full), 32'd0);
    end
    check("fill_full", 32'(full), 32'd1);
    load(24'hABCDEF);
    check("fill_still_full", 32'(full), 32'd1);
    play_edge();
    for (int i = 0; i < 4096; i++) tick(DW'(i + 24'h100000), i == 4095);
    drain();
    tick_none();
    idle(4);
    check("fill_busy_after", 32'(busy), 32'd0);
    check("final_done_alone", 32'(done_alone), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
